// File: rtl/masked_sbox_seq.sv
// Two-share sequencer feeding 16 nibbles through an external masked sbox.
// Optional PRESENT pLayer on each output share: MASKED_SBOX_SEQ_PLAYER_EN.
module masked_sbox_seq #(
  parameter int SBOX_LAT = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] in_s0,
  input  logic [63:0] in_s1,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  rnd,
  output logic [3:0]  sb_x_s0,
  output logic [3:0]  sb_x_s1,
  output logic        sb_r1,
  output logic        sb_r2,
  input  logic [3:0]  sb_y_s0,
  input  logic [3:0]  sb_y_s1,
  output logic [63:0] out_s0,
  output logic [63:0] out_s1,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [63:0] sh0;
  logic [63:0] sh1;
  logic [63:0] res0;
  logic [63:0] res1;

  logic [SBOX_LAT-1:0]       pv;
  logic [SBOX_LAT-1:0][3:0]  pidx;

  logic       issue;
  logic       cap;
  logic [3:0] cap_idx;
  logic       last_cap;

  assign issue    = (state == ISSUE);
  assign cap      = pv[SBOX_LAT-1];
  assign cap_idx  = pidx[SBOX_LAT-1];
  assign last_cap = cap && (cap_idx == 4'd15);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Each share gets its own gated mux; the two never meet.
  assign sb_x_s0 = issue ? sh0[{cnt, 2'b00} +: 4] : 4'd0;
  assign sb_x_s1 = issue ? sh1[{cnt, 2'b00} +: 4] : 4'd0;
  assign sb_r1   = issue & rnd[0];
  assign sb_r2   = issue & rnd[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      sh0   <= 64'd0;
      sh1   <= 64'd0;
    end else begin
      unique case (1'b1)
        state == IDLE: begin
          if (in_valid) begin
            sh0   <= in_s0;
            sh1   <= in_s1;
            cnt   <= 4'd0;
            state <= ISSUE;
          end
        end
        state == ISSUE: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15)
            state <= DRAIN;
        end
        state == DRAIN: begin
          if (last_cap)
            state <= DONE;
        end
        state == DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Valid/index delay line matching the sbox latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv   <= '0;
      pidx <= '0;
    end else begin
      for (int i = SBOX_LAT - 1; i > 0; i--) begin
        pv[i]   <= pv[i-1];
        pidx[i] <= pidx[i-1];
      end
      pv[0]   <= issue;
      pidx[0] <= cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res0 <= 64'd0;
      res1 <= 64'd0;
    end else if (cap) begin
      res0[{cap_idx, 2'b00} +: 4] <= sb_y_s0;
      res1[{cap_idx, 2'b00} +: 4] <= sb_y_s1;
    end
  end

`ifdef MASKED_SBOX_SEQ_PLAYER_EN
  function automatic logic [63:0] player(input logic [63:0] v);
    logic [63:0] p;
    p = 64'd0;
    for (int i = 0; i < 64; i++)
      p[16*(i%4) + i/4] = v[i];
    return p;
  endfunction

  assign out_s0 = player(res0);
  assign out_s1 = player(res1);
`else
  assign out_s0 = res0;
  assign out_s1 = res1;
`endif

endmodule
